// File: rtl/regfile_writeback_queue.sv
// Register file write-back queue: buffers ALU and load results, drains one per cycle
// onto the register file write port, and forwards the youngest queued value to operand fetch.
module regfile_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              in_ready,
  input  logic              drain_hold,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] fwd_rs1,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  input  logic [ADDR_W-1:0] fwd_rs2,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [ADDR_W-1:0] pending,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              push_mem;
  logic              push_alu;
  logic              pop;
  logic [PTR_W-1:0]  alu_slot;

  // Readiness depends only on registered occupancy so no input feeds back into it.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));

  assign push_mem = in_ready & mem_valid & (mem_rd != '0);
  assign push_alu = in_ready & alu_valid & (alu_rd != '0);
  assign alu_slot = wr_ptr + PTR_W'(push_mem);

  assign pop        = (count != '0) & ~drain_hold;
  assign RegWrite   = pop;
  assign Rd         = pop ? rd_mem[rd_ptr]   : '0;
  assign Write_data = pop ? data_mem[rd_ptr] : '0;
  assign pending    = ADDR_W'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push_mem) begin
        rd_mem[wr_ptr]   <= mem_rd;
        data_mem[wr_ptr] <= mem_data;
      end
      if (push_alu) begin
        rd_mem[alu_slot]   <= alu_rd;
        data_mem[alu_slot] <= alu_data;
      end
      wr_ptr <= wr_ptr + PTR_W'(push_mem) + PTR_W'(push_alu);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);
      if (!in_ready && (alu_valid || mem_valid)) overflow <= 1'b1;
    end
  end

  // Scan oldest to newest so the last match wins, giving the youngest value.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((fwd_rs1 != '0) && (rd_mem[idx] == fwd_rs1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem[idx];
        end
        if ((fwd_rs2 != '0) && (rd_mem[idx] == fwd_rs2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: hand-computed expectations checked
// with immediate assertions; inputs change and outputs are sampled on the falling edge.
module tb_regfile_writeback_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              in_ready;
  logic              drain_hold;
  logic              RegWrite;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] Write_data;
  logic [ADDR_W-1:0] fwd_rs1;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic [ADDR_W-1:0] fwd_rs2;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [ADDR_W-1:0] pending;
  logic              overflow;

  int n_checks = 0;
  int n_fails  = 0;

  regfile_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .in_ready(in_ready), .drain_hold(drain_hold),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
    .fwd_rs1(fwd_rs1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_rs2(fwd_rs2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .pending(pending), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] wd);
    check({tag, "_we"}, DATA_W'(RegWrite), DATA_W'(we));
    check({tag, "_rd"}, DATA_W'(Rd), DATA_W'(rd));
    check({tag, "_wd"}, Write_data, wd);
  endtask

  logic [ADDR_W-1:0] exp_rd [4];
  logic [DATA_W-1:0] exp_wd [4];

  initial begin
    rst_n = 1'b0; drain_hold = 1'b0; fwd_rs1 = '0; fwd_rs2 = '0;
    idle_inputs();
    #2;
    check_write("reset", 1'b0, '0, '0);
    check("reset_pending", DATA_W'(pending), 0);
    check("reset_overflow", DATA_W'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single ALU result, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5;
    #1 check("t1_in_ready", DATA_W'(in_ready), 1);
    check_write("t1_same_cycle", 1'b0, '0, '0);
    tick(); idle_inputs();
    #1 check_write("t1_write", 1'b1, 5'd5, 32'hA5);
    check("t1_pending1", DATA_W'(pending), 1);
    tick();
    #1 check("t1_pending0", DATA_W'(pending), 0);
    check_write("t1_idle", 1'b0, '0, '0);

    // 2: same-cycle mem+alu to the same register, forwarding picks the alu (newer) value
    drain_hold = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'd1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd2;
    fwd_rs1 = 5'd7;
    #1 check("t2_no_fwd_inflight", DATA_W'(fwd_hit1), 0);
    tick(); idle_inputs(); fwd_rs2 = 5'd3;
    #1 check("t2_hit1", DATA_W'(fwd_hit1), 1);
    check("t2_data1", fwd_data1, 32'd2);
    check("t2_miss_hit2", DATA_W'(fwd_hit2), 0);
    check("t2_miss_data2", fwd_data2, 0);
    check("t2_pending", DATA_W'(pending), 2);
    check_write("t2_held", 1'b0, '0, '0);
    drain_hold = 1'b0;
    #1 check_write("t2_first", 1'b1, 5'd7, 32'd1);
    tick();
    #1 check_write("t2_second", 1'b1, 5'd7, 32'd2);
    check("t2_head_fwd", fwd_data1, 32'd2);
    tick();
    #1 check("t2_done_hit", DATA_W'(fwd_hit1), 0);
    check("t2_done_pending", DATA_W'(pending), 0);

    // 3: writes to x0 are discarded
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF; fwd_rs1 = 5'd0; fwd_rs2 = '0;
    tick(); idle_inputs();
    #1 check("t3_pending", DATA_W'(pending), 0);
    check("t3_regwrite", DATA_W'(RegWrite), 0);
    check("t3_hit", DATA_W'(fwd_hit1), 0);
    check("t3_data", fwd_data1, 0);

    // 4: fill, overflow, drain in order with pointer wrap
    drain_hold = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    tick();
    mem_rd = 5'd3; mem_data = 32'h33; alu_rd = 5'd4; alu_data = 32'h44;
    #1 check("t4_ready_at2", DATA_W'(in_ready), 1);
    check("t4_pending2", DATA_W'(pending), 2);
    tick(); idle_inputs();
    #1 check("t4_pending4", DATA_W'(pending), 4);
    check("t4_not_ready", DATA_W'(in_ready), 0);
    check("t4_no_overflow_yet", DATA_W'(overflow), 0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick(); idle_inputs();
    #1 check("t4_overflow", DATA_W'(overflow), 1);
    check("t4_pending_after_drop", DATA_W'(pending), 4);
    fwd_rs1 = 5'd9;
    #1 check("t4_dropped_not_fwd", DATA_W'(fwd_hit1), 0);
    exp_rd[0] = 5'd1; exp_wd[0] = 32'h11;
    exp_rd[1] = 5'd2; exp_wd[1] = 32'h22;
    exp_rd[2] = 5'd3; exp_wd[2] = 32'h33;
    exp_rd[3] = 5'd4; exp_wd[3] = 32'h44;
    drain_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_write($sformatf("t4_drain%0d", i), 1'b1, exp_rd[i], exp_wd[i]);
      tick();
    end
    #1 check("t4_empty", DATA_W'(pending), 0);
    check("t4_ready_again", DATA_W'(in_ready), 1);
    check("t4_overflow_sticky", DATA_W'(overflow), 1);

    // 5: reset while draining with three queued entries
    drain_hold = 1'b1; fwd_rs1 = '0;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB;
    tick();
    mem_valid = 1'b0; alu_rd = 5'd12; alu_data = 32'hC;
    tick(); idle_inputs();
    #1 check("t5_pending3", DATA_W'(pending), 3);
    check("t5_not_ready_at3", DATA_W'(in_ready), 0);
    drain_hold = 1'b0;
    #1 check_write("t5_draining", 1'b1, 5'd10, 32'hA);
    rst_n = 1'b0;
    #1 check_write("t5_reset", 1'b0, '0, '0);
    check("t5_pending", DATA_W'(pending), 0);
    check("t5_overflow", DATA_W'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
